// File: rtl/regfile_sb_if.sv
// Bus bundle between decode/writeback and the register file with pending-write scoreboard.
// The master side drives addresses and strobes; the slave side returns operands and busy flags.
interface regfile_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic              busy_a;
  logic              busy_b;
  logic              iss_en;
  logic [ADDR_W-1:0] iss_addr;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W:0]   pend_cnt;
  logic [DATA_W-1:0] dbg_data;

  modport master (
    output rd_addr_a, rd_addr_b, iss_en, iss_addr, wr_en, wr_addr, wr_data,
    input  rd_data_a, rd_data_b, busy_a, busy_b, pend_cnt, dbg_data
  );

  modport slave (
    input  rd_addr_a, rd_addr_b, iss_en, iss_addr, wr_en, wr_addr, wr_data,
    output rd_data_a, rd_data_b, busy_a, busy_b, pend_cnt, dbg_data
  );
endinterface

// File: rtl/regfile_sb.sv
// Register file with per-register pending bits for RAW hazard detection (x0 hardwired to zero).
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_sb #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int DBG_IDX = 8
) (
  input logic          clk,
  input logic          rst,
  regfile_sb_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] DBG_A = ADDR_W'(DBG_IDX);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  pend;
  logic [DEPTH-1:0]  pend_nxt;
  logic [ADDR_W:0]   cnt;
  logic [ADDR_W:0]   cnt_nxt;
  logic              wr_live;
  logic              iss_live;
  logic              cnt_inc;
  logic              cnt_dec;

  assign wr_live  = bus.wr_en  && (bus.wr_addr  != '0);
  assign iss_live = bus.iss_en && (bus.iss_addr != '0);

  // Clear first, then set, so a same-edge issue to the written register keeps it pending.
  always_comb begin
    pend_nxt = pend;
    if (wr_live)  pend_nxt[bus.wr_addr]  = 1'b0;
    if (iss_live) pend_nxt[bus.iss_addr] = 1'b1;
  end

  assign cnt_inc = iss_live && !pend[bus.iss_addr];
  assign cnt_dec = wr_live && pend[bus.wr_addr] && !(iss_live && (bus.iss_addr == bus.wr_addr));

  always_comb begin
    cnt_nxt = cnt;
    case ({cnt_inc, cnt_dec})
      2'b10:   cnt_nxt = cnt + 1'b1;
      2'b01:   cnt_nxt = cnt - 1'b1;
      default: cnt_nxt = cnt;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      pend <= '0;
      cnt  <= '0;
    end else begin
      if (wr_live) mem[bus.wr_addr] <= bus.wr_data;
      pend <= pend_nxt;
      cnt  <= cnt_nxt;
    end
  end

  assign bus.pend_cnt = cnt;

`ifdef REGFILE_BYPASS_EN
  logic hit_a, hit_b, hit_dbg, iss_a, iss_b;

  assign hit_a   = wr_live && (bus.wr_addr == bus.rd_addr_a);
  assign hit_b   = wr_live && (bus.wr_addr == bus.rd_addr_b);
  assign hit_dbg = wr_live && (bus.wr_addr == DBG_A);
  assign iss_a   = iss_live && (bus.iss_addr == bus.rd_addr_a);
  assign iss_b   = iss_live && (bus.iss_addr == bus.rd_addr_b);

  // A forwarded operand is no longer outstanding unless a newer producer issues this cycle.
  assign bus.rd_data_a = hit_a ? bus.wr_data : mem[bus.rd_addr_a];
  assign bus.rd_data_b = hit_b ? bus.wr_data : mem[bus.rd_addr_b];
  assign bus.busy_a    = (hit_a && !iss_a) ? 1'b0 : pend[bus.rd_addr_a];
  assign bus.busy_b    = (hit_b && !iss_b) ? 1'b0 : pend[bus.rd_addr_b];
  assign bus.dbg_data  = hit_dbg ? bus.wr_data : mem[DBG_A];
`else
  assign bus.rd_data_a = mem[bus.rd_addr_a];
  assign bus.rd_data_b = mem[bus.rd_addr_b];
  assign bus.busy_a    = pend[bus.rd_addr_a];
  assign bus.busy_b    = pend[bus.rd_addr_b];
  assign bus.dbg_data  = mem[DBG_A];
`endif
endmodule
